ifu_fetch_ctrl: RTL

- Instruction-fetch controller directly upstream of the single-cycle core datapath; produces the 32-bit instruction that feeds the core's instr_in.
- Takes the current PC from the PC register and issues a valid/ready request to instruction memory over a 64-bit bus.
- Selects the 32-bit lane of the response and holds instruction + PC stable until the core consumes them.
- Handles flush/redirect, misaligned PCs and memory timeouts.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_timeout_cnt.sv | 32 +++
 rtl/ifu_fetch_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
//   fetch_state_e    : fetch controller state
//   INSTR_NOP        : instruction presented when a fetch faults
//   DEFAULT_RESET_PC : instr_pc value after reset
//   TIMEOUT_W        : width of the WAIT-state timeout counter
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam logic [31:0]  INSTR_NOP        = 32'h0000_0013;
  localparam logic [63:0]  DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned  TIMEOUT_W        = 8;
  localparam int unsigned  DEFAULT_TIMEOUT  = 255;

endpackage

// File: rtl/ifu_timeout_cnt.sv
// Saturating cycle counter used to bound the wait for a memory response.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : restart the count from zero (priority over enable)
//   enable   : advance the count by one
//   terminal : count has reached TIMEOUT (count saturates there)
module ifu_timeout_cnt
  import ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [TIMEOUT_W-1:0] count;

  assign terminal = (count == TIMEOUT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: issues a valid/ready request for the
// doubleword holding fetch_pc, selects the 32-bit lane and holds the
// instruction and its PC until the core asks for the next one.
//   clk, rst           : clock, asynchronous active-low reset
//   fetch_pc, fetch_go : PC to fetch and its request pulse
//   flush              : discard any in-flight fetch
//   imem_req_*         : request channel (8-byte aligned address)
//   imem_rsp_*         : response channel (data, error)
//   instr_out/pc/valid : instruction presented to the core
//   fetch_fault        : presented instruction is a faulted fetch
//   busy               : a request is outstanding (REQ or WAIT)
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_go,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [63:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  output logic            fetch_fault,
  output logic            busy
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, pend_pc_q;
  logic            drop_q, pend_q;
  logic            wait_tc;

  logic            idle_or_hold, in_flight, drop_eff, pend_set;
  logic            handshake, rsp_done, to_done, resolve, start, start_mis;
  logic [XLEN-1:0] start_pc;
  logic [31:0]     rsp_lane;

  logic            req_valid_d, instr_valid_d, fault_d, drop_d, pend_d;
  logic [XLEN-1:0] imem_addr_d, instr_pc_d, addr_d, pend_pc_d;
  logic [31:0]     instr_d;

  ifu_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (handshake),
    .enable   (state_q == WAIT),
    .terminal (wait_tc)
  );

  // A flush arriving in the same cycle as a response or fetch_go counts as
  // already set, so a coincident response is discarded and fetch_go is queued.
  always_comb begin
    idle_or_hold = (state_q == IDLE) || (state_q == HOLD);
    in_flight    = (state_q == REQ) || (state_q == WAIT);
    drop_eff     = drop_q || flush;
    pend_set     = in_flight && fetch_go && drop_eff;
    handshake    = (state_q == REQ) && imem_req_ready;
    rsp_done     = (state_q == WAIT) && imem_rsp_valid;
    to_done      = (state_q == WAIT) && !imem_rsp_valid && wait_tc;
    resolve      = rsp_done || to_done;
    start        = (idle_or_hold && fetch_go) ||
                   (resolve && drop_eff && (pend_q || pend_set));
    start_pc     = (idle_or_hold || pend_set) ? fetch_pc : pend_pc_q;
    start_mis    = (start_pc[1:0] != 2'b00);
    rsp_lane     = addr_q[2] ? imem_rsp_data[63:32] : imem_rsp_data[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = start_mis ? HOLD : REQ;
    end else begin
      case (state_q)
        HOLD:    if (flush) state_d = IDLE;
        REQ:     if (imem_req_ready) state_d = WAIT;
        WAIT:    if (resolve) state_d = drop_eff ? IDLE : HOLD;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    req_valid_d   = imem_req_valid;
    imem_addr_d   = imem_addr;
    instr_d       = instr_out;
    instr_pc_d    = instr_pc;
    instr_valid_d = instr_valid;
    fault_d       = fetch_fault;
    addr_d        = addr_q;
    drop_d        = drop_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;

    if (handshake) req_valid_d = 1'b0;

    if (resolve) begin
      drop_d = 1'b0;
      pend_d = 1'b0;
    end else begin
      if (in_flight && flush) drop_d = 1'b1;
      if (pend_set) begin
        pend_d    = 1'b1;
        pend_pc_d = fetch_pc;
      end
    end

    if (start) begin
      addr_d        = start_pc;
      instr_valid_d = 1'b0;
      if (start_mis) begin
        instr_valid_d = 1'b1;
        fault_d       = 1'b1;
        instr_d       = INSTR_NOP;
        instr_pc_d    = start_pc;
      end else begin
        req_valid_d = 1'b1;
        imem_addr_d = {start_pc[XLEN-1:3], 3'b000};
      end
    end else if (resolve && !drop_eff) begin
      instr_valid_d = 1'b1;
      instr_pc_d    = addr_q;
      fault_d       = rsp_done ? imem_rsp_err : 1'b1;
      instr_d       = (rsp_done && !imem_rsp_err) ? rsp_lane : INSTR_NOP;
    end else if (state_q == HOLD && flush) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req_valid <= 1'b0;
      imem_addr      <= '0;
      instr_out      <= INSTR_NOP;
      instr_pc       <= RESET_PC;
      instr_valid    <= 1'b0;
      fetch_fault    <= 1'b0;
      busy           <= 1'b0;
      addr_q         <= '0;
      drop_q         <= 1'b0;
      pend_q         <= 1'b0;
      pend_pc_q      <= '0;
    end else begin
      imem_req_valid <= req_valid_d;
      imem_addr      <= imem_addr_d;
      instr_out      <= instr_d;
      instr_pc       <= instr_pc_d;
      instr_valid    <= instr_valid_d;
      fetch_fault    <= fault_d;
      busy           <= (state_d == REQ) || (state_d == WAIT);
      addr_q         <= addr_d;
      drop_q         <= drop_d;
      pend_q         <= pend_d;
      pend_pc_q      <= pend_pc_d;
    end
  end

  // fetch_go while a live (not dropped) fetch is outstanding is a core bug.
  a_go_while_busy: assert property (@(posedge clk) disable iff (!rst)
    !(busy && fetch_go && !drop_q && !flush));

endmodule
